// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - game sequencer: IDLE/PLAY/PAUSE/WIN/LOSE flow, lives, streak, level and scroll speed
module game_flow_ctrl #(
  parameter int unsigned MAX_LIVES    = 3,
  parameter logic [22:0] DIFF_START   = 23'd5_000_000,
  parameter logic [22:0] DIFF_STEP    = 23'd500_000,
  parameter logic [22:0] DIFF_MIN     = 23'd1_000_000,
  parameter int unsigned STREAK_LEVEL = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic        hit,
  input  logic        missed,
  input  logic [7:0]  num_hits,
  input  logic [7:0]  num_misses,
  input  logic [7:0]  song_notes,
  output logic [2:0]  mode,
  output logic [22:0] diff,
  output logic [2:0]  lives,
  output logic [7:0]  streak,
  output logic [3:0]  level,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_PAUSE = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_e;

  localparam logic [2:0]  LIVES_INIT   = MAX_LIVES[2:0];
  localparam logic [7:0]  LEVEL_TARGET = STREAK_LEVEL[7:0];
  localparam logic [23:0] DIFF_KNEE    = {1'b0, DIFF_MIN} + {1'b0, DIFF_STEP};

  state_e      mode_q, mode_d;
  logic [22:0] diff_q, diff_d;
  logic [2:0]  lives_q, lives_d;
  logic [7:0]  streak_q, streak_d;
  logic [3:0]  level_q, level_d;
  logic [7:0]  level_cnt_q, level_cnt_d;
  logic        game_over_q, game_over_d;

  // bit 0 = start, bit 1 = pause
  logic [1:0]  btn_s1_q, btn_s1_d;
  logic [1:0]  btn_s2_q, btn_s2_d;
  logic [1:0]  btn_prev_q, btn_prev_d;
  logic [1:0]  press_q, press_d;

  logic        start_press, pause_press, notes_done;
  logic [8:0]  notes_seen;
  logic [7:0]  cnt_inc;

  assign start_press = press_q[0];
  assign pause_press = press_q[1];
  assign notes_seen  = {1'b0, num_hits} + {1'b0, num_misses};
  assign notes_done  = (song_notes != 8'd0) && (notes_seen >= {1'b0, song_notes});
  assign cnt_inc     = level_cnt_q + 8'd1;

  always_comb begin
    btn_s1_d    = {pause_btn, start_btn};
    btn_s2_d    = btn_s1_q;
    btn_prev_d  = btn_s2_q;
    press_d     = btn_s2_q & ~btn_prev_q;
    mode_d      = mode_q;
    diff_d      = diff_q;
    lives_d     = lives_q;
    streak_d    = streak_q;
    level_d     = level_q;
    level_cnt_d = level_cnt_q;

    case (mode_q)
      S_IDLE: begin
        if (start_press) begin
          mode_d      = S_PLAY;
          lives_d     = LIVES_INIT;
          diff_d      = DIFF_START;
          streak_d    = 8'd0;
          level_d     = 4'd0;
          level_cnt_d = 8'd0;
        end
      end
      S_PLAY: begin
        // a simultaneous hit is dropped when a miss lands in the same cycle
        if (missed) begin
          lives_d     = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
          streak_d    = 8'd0;
          level_cnt_d = 8'd0;
        end else if (hit) begin
          streak_d = (streak_q == 8'hFF) ? streak_q : streak_q + 8'd1;
          if (cnt_inc == LEVEL_TARGET) begin
            level_cnt_d = 8'd0;
            level_d     = (level_q == 4'hF) ? level_q : level_q + 4'd1;
            diff_d      = ({1'b0, diff_q} < DIFF_KNEE) ? DIFF_MIN : diff_q - DIFF_STEP;
          end else begin
            level_cnt_d = cnt_inc;
          end
        end

        if (pause_press)
          mode_d = S_PAUSE;
        else if (missed && (lives_q == 3'd1))
          mode_d = S_LOSE;
        else if (notes_done)
          mode_d = S_WIN;
      end
      S_PAUSE: begin
        if (pause_press)
          mode_d = S_PLAY;
      end
      S_WIN, S_LOSE: begin
        if (start_press)
          mode_d = S_IDLE;
      end
      default: mode_d = S_IDLE;
    endcase

    game_over_d = (mode_d == S_WIN) || (mode_d == S_LOSE);
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      mode_q      <= S_IDLE;
      diff_q      <= DIFF_START;
      lives_q     <= LIVES_INIT;
      streak_q    <= 8'd0;
      level_q     <= 4'd0;
      level_cnt_q <= 8'd0;
      game_over_q <= 1'b0;
      btn_s1_q    <= 2'b00;
      btn_s2_q    <= 2'b00;
      btn_prev_q  <= 2'b00;
      press_q     <= 2'b00;
    end else begin
      mode_q      <= mode_d;
      diff_q      <= diff_d;
      lives_q     <= lives_d;
      streak_q    <= streak_d;
      level_q     <= level_d;
      level_cnt_q <= level_cnt_d;
      game_over_q <= game_over_d;
      btn_s1_q    <= btn_s1_d;
      btn_s2_q    <= btn_s2_d;
      btn_prev_q  <= btn_prev_d;
      press_q     <= press_d;
    end
  end

  assign mode      = mode_q;
  assign diff      = diff_q;
  assign lives     = lives_q;
  assign streak    = streak_q;
  assign level     = level_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - randomized and directed checks of game_flow_ctrl against a behavioural model
module tb_game_flow_ctrl;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        start_btn = 1'b0, pause_btn = 1'b0, hit = 1'b0, missed = 1'b0;
  logic [7:0]  num_hits = 8'd0, num_misses = 8'd0, song_notes = 8'd0;
  logic [2:0]  mode;
  logic [22:0] diff;
  logic [2:0]  lives;
  logic [7:0]  streak;
  logic [3:0]  level;
  logic        game_over;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  game_flow_ctrl dut (
    .clk(clk), .n_rst(n_rst), .start_btn(start_btn), .pause_btn(pause_btn),
    .hit(hit), .missed(missed), .num_hits(num_hits), .num_misses(num_misses),
    .song_notes(song_notes), .mode(mode), .diff(diff), .lives(lives),
    .streak(streak), .level(level), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: game state as plain integers; a button rise sampled at edge N acts at edge N+3.
  int m_mode, m_lives, m_streak, m_level, m_cnt, m_diff;
  int sh[0:3], ph[0:3];

  always @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      m_mode = 0; m_lives = 3; m_streak = 0; m_level = 0; m_cnt = 0; m_diff = 5_000_000;
      for (int i = 0; i < 4; i++) begin sh[i] = 0; ph[i] = 0; end
    end else begin
      bit sp, pp, lose, win;
      sp = (sh[2] == 1) && (sh[3] == 0);
      pp = (ph[2] == 1) && (ph[3] == 0);
      for (int i = 3; i > 0; i--) begin sh[i] = sh[i-1]; ph[i] = ph[i-1]; end
      sh[0] = int'(start_btn);
      ph[0] = int'(pause_btn);
      case (m_mode)
        0: if (sp) begin
          m_mode = 1; m_lives = 3; m_diff = 5_000_000; m_streak = 0; m_level = 0; m_cnt = 0;
        end
        1: begin
          lose = missed && (m_lives == 1);
          win  = (song_notes != 0) && (int'(num_hits) + int'(num_misses) >= int'(song_notes));
          if (missed) begin
            m_lives  = (m_lives > 0) ? m_lives - 1 : 0;
            m_streak = 0;
            m_cnt    = 0;
          end else if (hit) begin
            m_streak = (m_streak < 255) ? m_streak + 1 : 255;
            m_cnt++;
            if (m_cnt == 8) begin
              m_cnt   = 0;
              m_level = (m_level < 15) ? m_level + 1 : 15;
              m_diff  = (m_diff - 500_000 < 1_000_000) ? 1_000_000 : m_diff - 500_000;
            end
          end
          m_mode = pp ? 2 : lose ? 4 : win ? 3 : 1;
        end
        2: if (pp) m_mode = 1;
        default: if (sp) m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !n_rst) begin
      chk("mode", mode, m_mode);
      chk("lives", lives, m_lives);
      chk("streak", streak, m_streak);
      chk("level", level, m_level);
      chk("diff", diff, m_diff);
      chk("game_over", game_over, (m_mode == 3 || m_mode == 4) ? 1 : 0);
    end
  end

  task automatic cyc(input logic h, input logic m);
    hit = h; missed = m;
    @(negedge clk);
    hit = 1'b0; missed = 1'b0;
  endtask

  task automatic press(input bit is_pause);
    if (is_pause) pause_btn = 1'b1; else start_btn = 1'b1;
    repeat (2) @(negedge clk);
    pause_btn = 1'b0; start_btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_diff"}, diff, 5_000_000);
    chk({tag, "_lives"}, lives, 3);
    chk({tag, "_streak"}, streak, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_game_over"}, game_over, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    n_rst = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);

    // start held 5 cycles: PLAY exactly 3 edges after the first sampled high, once
    start_btn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 4) start_btn = 1'b0;
      chk("start_latency", mode, (i >= 3) ? 1 : 0);
    end
    chk("start_lives", lives, 3);
    chk("start_diff", diff, 5_000_000);

    repeat (8) cyc(1, 0);
    chk("lvl1_streak", streak, 8);
    chk("lvl1_level", level, 1);
    chk("lvl1_diff", diff, 4_500_000);
    repeat (80) cyc(1, 0);
    chk("sat_streak", streak, 88);
    chk("sat_level", level, 11);
    chk("sat_diff", diff, 1_000_000);

    cyc(0, 1);
    chk("miss1_lives", lives, 2);
    chk("miss1_streak", streak, 0);
    cyc(0, 0);
    cyc(0, 1);
    chk("miss2_lives", lives, 1);
    cyc(0, 1);
    chk("lose_mode", mode, 4);
    chk("lose_lives", lives, 0);
    chk("lose_go", game_over, 1);
    chk("lose_level", level, 11);
    press(0);
    chk("lose_to_idle", mode, 0);
    press(0);
    chk("restart_mode", mode, 1);
    chk("restart_lives", lives, 3);
    chk("restart_level", level, 0);

    // WIN boundary: one note short stays in PLAY
    song_notes = 8'd10; num_hits = 8'd6; num_misses = 8'd3;
    @(negedge clk);
    chk("win_short", mode, 1);
    num_hits = 8'd7;
    @(negedge clk);
    chk("win_mode", mode, 3);
    chk("win_go", game_over, 1);
    press(0);
    song_notes = 8'd0;
    press(0);
    chk("replay_mode", mode, 1);

    cyc(0, 1);
    cyc(0, 1);
    chk("prio_lives", lives, 1);
    song_notes = 8'd10; num_hits = 8'd7; num_misses = 8'd3;
    cyc(0, 1);
    chk("prio_mode", mode, 4);
    chk("prio_lives0", lives, 0);
    song_notes = 8'd0;
    press(0);
    press(0);
    chk("replay2_mode", mode, 1);

    press(1);
    chk("pause_mode", mode, 2);
    for (int i = 0; i < 6; i++) cyc(i[0], ~i[0]);
    chk("pause_lives", lives, 3);
    chk("pause_streak", streak, 0);
    chk("pause_diff", diff, 5_000_000);
    press(0);
    chk("pause_start_ign", mode, 2);
    press(1);
    chk("resume_mode", mode, 1);

    repeat (7) cyc(1, 0);
    chk("both_pre_streak", streak, 7);
    cyc(1, 1);
    chk("both_streak", streak, 0);
    chk("both_lives", lives, 2);
    chk("both_level", level, 0);
    repeat (5) cyc(1, 0);

    // asynchronous reset between clock edges
    @(posedge clk);
    #2 n_rst = 1'b1;
    #1 chk_reset_vals("async");
    @(negedge clk);
    n_rst = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      hit    = ($urandom % 3) == 0;
      missed = ($urandom % 9) == 0;
      if (($urandom % 30) == 0) start_btn = ~start_btn;
      if (($urandom % 45) == 0) pause_btn = ~pause_btn;
      if (($urandom % 120) == 0)
        song_notes = (($urandom % 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      num_hits   = 8'($urandom % 140);
      num_misses = 8'($urandom % 140);
      @(negedge clk);
    end

    hit = 1'b0; missed = 1'b0; start_btn = 1'b0; pause_btn = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
